matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Control block for the 8x8 TPU MMIO front end: decodes host accesses to the A/B/C/MatMul address windows and generates the A, B and C memory write strobes and row selects. It sequences a matrix multiply by holding the systolic-array enable high for exactly 3*DIM-2 cycles. It stalls host traffic while the array computes. It sits between the MMIO host port and the memA/memB/systolic_array datapath, replacing ad-hoc decode in the top level.

## Interface
Parameters:
- DIM, 8, matrix dimension (rows/cols of A, B, C)
- ADDRW, 16, MMIO address width

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  1  host access valid this cycle
- r_w  input  1  0 = read, 1 = write
- addr  input  ADDRW  host byte address
- ack  output  1  access accepted this cycle (combinational)
- addr_err  output  1  one-cycle pulse: accepted access to an unmapped or read-only-violating address
- wr_en_a  output  1  write row of A (combinational, qualified by ack)
- wr_en_b  output  1  write/shift B (combinational, qualified by ack)
- wr_en_c  output  1  write half-row of C (combinational, qualified by ack)
- a_row  output  $clog2(DIM)  A row select = addr[5:3]
- c_row  output  $clog2(DIM)  C row select = addr[6:4]
- c_half  output  1  C 64-bit half select = addr[3] (0 = columns 0..3, 1 = columns 4..7)
- arr_en  output  1  systolic array / memA / memB advance enable
- b_en  output  1  memB enable = wr_en_b | arr_en
- busy  output  1  high while computing
- done  output  1  one-cycle pulse on compute completion

## Operation
- Address map (addr[15:8]): 0x01 A window (W), 0x02 B window (W), 0x03 C window (R/W), addr == 0x0400 MatMul start (W). Anything else is unmapped.
- A window: offsets 0x00-0x3F. B window: offsets 0x00-0x3F. C window: offsets 0x00-0x7F. Offsets beyond a window's range are unmapped.
- ack = req & (state == IDLE). While COMPUTE, every request is stalled (ack = 0). The host holds req/addr/r_w until ack.
- Accepted write to A/B/C: the matching wr_en_* is 1 in that same cycle; the other two are 0.
- Accepted read of C: no strobe; c_row/c_half select the data.
- Reads of A, B or 0x0400: accepted, addr_err pulses, no other effect.
- Unmapped access (read or write): accepted, addr_err pulses, no other effect.
- Row selects and c_half are decoded continuously from addr; they are meaningful only when ack = 1 or during C readback.
- FSM states: IDLE, COMPUTE.
  - IDLE -> COMPUTE on an accepted write to 0x0400; cnt <= 0.
  - COMPUTE: arr_en = 1 and cnt increments each cycle. When cnt == 3*DIM-3 (the last enabled cycle), next state = IDLE.
  - On entering IDLE from COMPUTE, done = 1 for one cycle.
- cnt width is $clog2(3*DIM). No wrap within a run.
- busy = (state == COMPUTE).
- Asynchronous reset at any time, including mid-COMPUTE: state = IDLE, cnt = 0, done = 0. No done pulse is generated for an aborted run.

## Timing
- Reset values: ack 0 (while req 0), addr_err 0, wr_en_a/b/c 0, arr_en 0, b_en 0, busy 0, done 0.
- ack, wr_en_*, row selects and b_en are combinational from req/addr/r_w/state (same cycle). addr_err and done are registered.
- Start write accepted at edge N. From edge N+1, arr_en = 1 and busy = 1 for exactly 3*DIM-2 cycles (22 for DIM = 8). At the next edge, arr_en = 0, busy = 0, done = 1 for one cycle, and ack is available again that same cycle.
- A start write in the cycle done is high is accepted and begins a new run; back-to-back runs have one idle cycle between them.
- A request pending while busy is accepted in the first IDLE cycle.

## Test plan
- Reset mid-stream: assert rst_n = 0 with req = 1, addr = 0x0400, r_w = 1 -> all outputs 0 except ack is forced 0 during reset; after release, ack = 1 the same cycle.
- Write 0x0108 with r_w = 1 -> ack = 1, wr_en_a = 1, a_row = 1. Write 0x0238 -> wr_en_b = 1, b_en = 1. Write 0x0378 -> wr_en_c = 1, c_row = 7, c_half = 1.
- Start at 0x0400 -> arr_en high for exactly 22 cycles, busy matches, then done = 1 for one cycle; count arr_en cycles = 22.
- During compute, issue a C read at 0x0310 -> ack = 0 for all remaining busy cycles, then ack = 1 in the cycle done = 1, c_row = 1, c_half = 0.
- Error accesses: read 0x0100, write 0x0500, write 0x0140 -> each acked, addr_err pulses the next cycle, no wr_en_* and no arr_en.
- Reset at compute cycle 10 -> arr_en and busy drop immediately, no done pulse. A new start afterwards runs the full 22 cycles.

Source files
------------

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - MMIO decode and matmul compute sequencer for the 8x8 TPU front end.
// Decodes A/B/C/start windows into write strobes and row selects; holds arr_en for 3*DIM-2 cycles.
module matmul_sequencer #(
   parameter int DIM   = 8,
   parameter int ADDRW = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req,
   input  logic                    r_w,
   input  logic [ADDRW-1:0]        addr,
   output logic                    ack,
   output logic                    addr_err,
   output logic                    wr_en_a,
   output logic                    wr_en_b,
   output logic                    wr_en_c,
   output logic [$clog2(DIM)-1:0]  a_row,
   output logic [$clog2(DIM)-1:0]  c_row,
   output logic                    c_half,
   output logic                    arr_en,
   output logic                    b_en,
   output logic                    busy,
   output logic                    done
);

   localparam int RW = $clog2(DIM);
   localparam int CW = $clog2(3*DIM);
   localparam int PW = ADDRW - 8;
   localparam logic [CW-1:0]    LAST_CNT  = CW'(3*DIM-3);
   localparam logic [7:0]       AB_LIMIT  = 8'(DIM*8);
   localparam logic [7:0]       C_LIMIT   = 8'(DIM*16);
   localparam logic [ADDRW-1:0] START_ADR = ADDRW'(16'h0400);

   typedef enum logic {S_IDLE, S_COMPUTE} state_t;

   state_t         r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic           r_done, w_done_nxt;
   logic           r_addr_err;

   logic [PW-1:0]  w_page;
   logic [7:0]     w_off;
   logic           w_a_hit, w_b_hit, w_c_hit, w_start_hit;
   logic           w_legal, w_err, w_start;

   // Window decode is purely a function of the address; the access type only matters for legality.
   always_comb begin
      w_page      = addr[ADDRW-1:8];
      w_off       = addr[7:0];
      w_a_hit     = (w_page == PW'(1)) && (w_off < AB_LIMIT);
      w_b_hit     = (w_page == PW'(2)) && (w_off < AB_LIMIT);
      w_c_hit     = (w_page == PW'(3)) && (w_off < C_LIMIT);
      w_start_hit = (addr == START_ADR);
      w_legal     = r_w ? (w_a_hit | w_b_hit | w_c_hit | w_start_hit) : w_c_hit;
   end

   // Held in reset the host must not see an accept, even with req asserted.
   always_comb begin
      ack     = req & rst_n & (r_state == S_IDLE);
      wr_en_a = ack & r_w & w_a_hit;
      wr_en_b = ack & r_w & w_b_hit;
      wr_en_c = ack & r_w & w_c_hit;
      w_start = ack & r_w & w_start_hit;
      w_err   = ack & ~w_legal;
      a_row   = addr[3 +: RW];
      c_row   = addr[4 +: RW];
      c_half  = addr[3];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      arr_en      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = S_COMPUTE;
               w_cnt_nxt   = '0;
            end
         end
         S_COMPUTE: begin
            arr_en = 1'b1;
            if (r_cnt == LAST_CNT) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_done     <= 1'b0;
         r_addr_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_done     <= w_done_nxt;
         r_addr_err <= w_err;
      end
   end

   always_comb begin
      busy     = (r_state == S_COMPUTE);
      b_en     = wr_en_b | arr_en;
      done     = r_done;
      addr_err = r_addr_err;
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - randomized self-checking bench for matmul_sequencer.
// A cycle-level behavioural model (remaining compute cycles, pending pulses) predicts every output.
module tb_matmul_sequencer;

   localparam int DIM = 8;
   localparam int RUN = 3*DIM-2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        r_w = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        ack, addr_err, wr_en_a, wr_en_b, wr_en_c, c_half, arr_en, b_en, busy, done;
   logic [2:0]  a_row, c_row;

   int n_checks = 0;
   int n_errors = 0;

   int m_left = 0;
   bit m_done = 0;
   bit m_err  = 0;
   int run_len = 0;

   matmul_sequencer #(.DIM(DIM), .ADDRW(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .r_w(r_w), .addr(addr),
      .ack(ack), .addr_err(addr_err), .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_en_c(wr_en_c),
      .a_row(a_row), .c_row(c_row), .c_half(c_half), .arr_en(arr_en), .b_en(b_en),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t addr=%h r_w=%0d)", tag, obs, exp, $time, addr, r_w);
      end
   endtask

   // 0 error, 1 A write, 2 B write, 3 C write, 4 C read, 5 start
   function automatic int kind_of(input logic [15:0] a, input logic w);
      int page, off;
      page = int'(a) / 256;
      off  = int'(a) % 256;
      if (w && a == 16'h0400)          return 5;
      if (w && page == 1 && off < 64)  return 1;
      if (w && page == 2 && off < 64)  return 2;
      if (page == 3 && off < 128)      return w ? 3 : 4;
      return 0;
   endfunction

   task automatic step(input logic rq, input logic rw, input logic [15:0] ad, output bit acked);
      int k, n_left;
      bit e_ack;
      req = rq; r_w = rw; addr = ad;
      @(negedge clk);
      k     = kind_of(ad, rw);
      e_ack = rq && (m_left == 0);
      chk("ack",      ack,      e_ack);
      chk("wr_en_a",  wr_en_a,  e_ack && k == 1);
      chk("wr_en_b",  wr_en_b,  e_ack && k == 2);
      chk("wr_en_c",  wr_en_c,  e_ack && k == 3);
      chk("arr_en",   arr_en,   m_left > 0);
      chk("busy",     busy,     m_left > 0);
      chk("b_en",     b_en,     (e_ack && k == 2) || m_left > 0);
      chk("done",     done,     m_done);
      chk("addr_err", addr_err, m_err);
      chk("a_row",    a_row,    (int'(ad) / 8) % 8);
      chk("c_row",    c_row,    (int'(ad) / 16) % 8);
      chk("c_half",   c_half,   (int'(ad) / 8) % 2);
      if (arr_en) run_len++;
      if (m_done) begin
         chk("run_len", run_len, RUN);
         run_len = 0;
      end
      n_left = (m_left > 0) ? m_left - 1 : 0;
      m_done = (m_left == 1);
      if (e_ack && k == 5) n_left = RUN;
      m_err  = e_ack && k == 0;
      m_left = n_left;
      acked  = e_ack;
      @(posedge clk);
      #1;
   endtask

   // Asserts reset mid-cycle with a start request held on the bus.
   task automatic mid_reset();
      req = 1'b1; r_w = 1'b1; addr = 16'h0400;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_arr_en", arr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_wr_en", {wr_en_a, wr_en_b, wr_en_c}, 0);
      chk("rst_b_en", b_en, 0);
      m_left = 0; m_done = 0; m_err = 0; run_len = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit acked, pend, prw;
      logic [15:0] pad;
      int stalls;
      #3;
      chk("reset_ack_idle", ack, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(posedge clk); #1;
      mid_reset();

      step(1, 1, 16'h0400, acked);
      for (int i = 0; i < RUN + 2; i++) step(0, 0, 16'h0000, acked);
      step(1, 1, 16'h0108, acked);
      step(1, 1, 16'h0238, acked);
      step(1, 1, 16'h0378, acked);
      step(1, 0, 16'h0100, acked);
      step(1, 1, 16'h0500, acked);
      step(1, 1, 16'h0140, acked);
      step(0, 0, 16'h0000, acked);

      step(1, 1, 16'h0400, acked);
      stalls = 0;
      acked = 0;
      for (int i = 0; i < 40 && !acked; i++) begin
         step(1, 0, 16'h0310, acked);
         if (!acked) stalls++;
      end
      chk("stall_cycles", stalls, RUN);
      chk("read_acked", acked, 1);

      step(1, 1, 16'h0400, acked);
      for (int i = 0; i < 10; i++) step(0, 0, 16'h0000, acked);
      mid_reset();
      step(1, 1, 16'h0400, acked);
      for (int i = 0; i < RUN + 3; i++) step(0, 0, 16'h0000, acked);

      step(1, 1, 16'h0400, acked);
      for (int i = 0; i < RUN; i++) step(0, 0, 16'h0000, acked);
      step(1, 1, 16'h0400, acked);
      for (int i = 0; i < RUN + 2; i++) step(0, 0, 16'h0000, acked);

      pend = 0; prw = 0; pad = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!pend && $urandom_range(0, 9) < 7) begin
            pend = 1;
            prw  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
               0: pad = 16'h0100 | 16'($urandom_range(0, 63));
               1: pad = 16'h0200 | 16'($urandom_range(0, 63));
               2, 3: pad = 16'h0300 | 16'($urandom_range(0, 127));
               4: pad = 16'h0100 | 16'($urandom_range(64, 255));
               5: pad = 16'h0300 | 16'($urandom_range(128, 255));
               6: pad = 16'($urandom_range(0, 65535));
               7: pad = 16'h0401;
               default: begin pad = 16'h0400; prw = ($urandom_range(0, 3) != 0); end
            endcase
         end
         if (pend) begin
            step(1, prw, pad, acked);
            if (acked) pend = 0;
         end else begin
            step(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), acked);
         end
         if ($urandom_range(0, 999) == 0) mid_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
